// File: rtl/mul_mant_iter.sv
// Iterative radix-2 shift-add mantissa multiplier with a leading-one count for the normaliser.
// Optional MUL_STICKY_EN adds o_sticky, the OR of the product bits below the result window.
module mul_mant_iter #(
   parameter int SIZE_DATA = 24,
   parameter int SIZE_LOPD = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [SIZE_DATA-1:0] i_mant_a,
   input  logic [SIZE_DATA-1:0] i_mant_b,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [SIZE_DATA-1:0] o_mantissa,
   output logic                 o_overflow,
   output logic                 o_zero_flag,
   output logic [SIZE_LOPD-1:0] o_one_position
`ifdef MUL_STICKY_EN
   ,
   output logic                 o_sticky
`endif
);

   localparam int N  = SIZE_DATA;
   localparam int CW = $clog2(SIZE_DATA + 1);

   typedef enum logic [1:0] {IDLE, BUSY, NORM, DONE} state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       a_q, a_d;
   logic [2*N-1:0]     acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [N-1:0]       mant_q, mant_d;
   logic               ov_q, ov_d;
   logic               zf_q, zf_d;
   logic [SIZE_LOPD-1:0] pos_q, pos_d;
`ifdef MUL_STICKY_EN
   logic               sticky_q, sticky_d;
`endif

   logic [N-1:0]       addend;
   logic [N:0]         sum;
   logic [SIZE_LOPD-1:0] lz;

   // Multiplier b sits in the low half and shifts out LSB-first; partial sums enter from the top.
   always_comb begin
      addend = acc_q[0] ? a_q : '0;
      sum    = {1'b0, acc_q[2*N-1:N]} + {1'b0, addend};
   end

   // Highest set bit wins; an all-zero window saturates at N-1.
   always_comb begin
      lz = SIZE_LOPD'(N - 1);
      for (int i = 0; i < N; i++)
         if (mant_q[i]) lz = SIZE_LOPD'(N - 1 - i);
      if (ov_q) lz = '0;
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mant_d   = mant_q;
      ov_d     = ov_q;
      zf_d     = zf_q;
      pos_d    = pos_q;
`ifdef MUL_STICKY_EN
      sticky_d = sticky_q;
`endif
      case (state_q)
         IDLE: if (i_valid) begin
            if (i_mant_a == '0 || i_mant_b == '0) begin
               state_d  = DONE;
               zf_d     = 1'b1;
               mant_d   = '0;
               ov_d     = 1'b0;
               pos_d    = '0;
`ifdef MUL_STICKY_EN
               sticky_d = 1'b0;
`endif
            end else begin
               state_d = BUSY;
               a_d     = i_mant_a;
               acc_d   = {{N{1'b0}}, i_mant_b};
               cnt_d   = '0;
            end
         end
         BUSY: begin
            acc_d = {sum, acc_q[N-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               state_d  = NORM;
               mant_d   = acc_d[2*N-2:N-1];
               ov_d     = acc_d[2*N-1];
               zf_d     = 1'b0;
`ifdef MUL_STICKY_EN
               sticky_d = |acc_d[N-2:0];
`endif
            end
         end
         NORM: begin
            pos_d   = lz;
            state_d = DONE;
         end
         DONE: if (i_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         mant_q   <= '0;
         ov_q     <= 1'b0;
         zf_q     <= 1'b0;
         pos_q    <= '0;
`ifdef MUL_STICKY_EN
         sticky_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         mant_q   <= mant_d;
         ov_q     <= ov_d;
         zf_q     <= zf_d;
         pos_q    <= pos_d;
`ifdef MUL_STICKY_EN
         sticky_q <= sticky_d;
`endif
      end
   end

   assign o_ready        = (state_q == IDLE);
   assign o_valid        = (state_q == DONE);
   assign o_mantissa     = mant_q;
   assign o_overflow     = ov_q;
   assign o_zero_flag    = zf_q;
   assign o_one_position = pos_q;
`ifdef MUL_STICKY_EN
   assign o_sticky       = sticky_q;
`endif

endmodule

// File: tb/tb_mul_mant_iter.sv
// Directed scoreboard bench for mul_mant_iter: latency, result fields, back-pressure and reset abort.
module tb_mul_mant_iter;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [23:0] i_mant_a = '0;
   logic [23:0] i_mant_b = '0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [23:0] o_mantissa;
   logic        o_overflow;
   logic        o_zero_flag;
   logic [4:0]  o_one_position;
`ifdef MUL_STICKY_EN
   logic        o_sticky;
`endif

   typedef struct packed {
      logic [23:0] mant;
      logic        ov;
      logic        zf;
      logic [4:0]  pos;
      logic        st;
      logic [7:0]  lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   mul_mant_iter #(.SIZE_DATA(24), .SIZE_LOPD(5)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_mant_a(i_mant_a), .i_mant_b(i_mant_b), .o_valid(o_valid), .i_ready(i_ready),
      .o_mantissa(o_mantissa), .o_overflow(o_overflow), .o_zero_flag(o_zero_flag),
      .o_one_position(o_one_position)
`ifdef MUL_STICKY_EN
      , .o_sticky(o_sticky)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   function automatic exp_t model(input logic [23:0] a, input logic [23:0] b);
      exp_t        e;
      logic [47:0] p;
      logic [23:0] m;
      p = {24'd0, a} * {24'd0, b};
      e.zf   = (a == 0) || (b == 0);
      e.mant = p[46:23];
      e.ov   = p[47];
      e.st   = |p[22:0];
      e.lat  = e.zf ? 8'd1 : 8'd26;
      e.pos  = 0;
      m = e.mant;
      if (!e.ov && !e.zf)
         while (e.pos < 23 && !m[23]) begin
            m = m << 1;
            e.pos++;
         end
      return e;
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ready"}, o_ready, 1);
      chk({tag, "_valid"}, o_valid, 0);
      chk({tag, "_mant"},  o_mantissa, 0);
      chk({tag, "_ov"},    o_overflow, 0);
      chk({tag, "_zf"},    o_zero_flag, 0);
      chk({tag, "_pos"},   o_one_position, 0);
`ifdef MUL_STICKY_EN
      chk({tag, "_st"},    o_sticky, 0);
`endif
   endtask

   task automatic check_result(input string tag, input exp_t e);
      chk({tag, "_mant"}, o_mantissa, e.mant);
      chk({tag, "_ov"},   o_overflow, e.ov);
      chk({tag, "_zf"},   o_zero_flag, e.zf);
      chk({tag, "_pos"},  o_one_position, e.pos);
`ifdef MUL_STICKY_EN
      chk({tag, "_st"},   o_sticky, e.st);
`endif
   endtask

   // Accept one operand pair, wait (bounded) for the result, compare; optionally back-pressure.
   task automatic run(input string tag, input logic [23:0] a, input logic [23:0] b, input bit hold);
      int   lat;
      exp_t e;
      @(negedge i_clk);
      chk({tag, "_rdy_acc"}, o_ready, 1);
      i_ready  = !hold;
      i_valid  = 1'b1;
      i_mant_a = a;
      i_mant_b = b;
      exp_q.push_back(model(a, b));
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 100) begin
         @(posedge i_clk); #1;
         lat++;
      end
      e = exp_q.pop_front();
      chk({tag, "_seen"}, o_valid, 1);
      chk({tag, "_lat"}, lat, e.lat);
      check_result(tag, e);
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            i_valid  = i[0];
            i_mant_a = $urandom_range(1, 24'hFFFFFF);
            i_mant_b = $urandom_range(1, 24'hFFFFFF);
            @(posedge i_clk); #1;
            chk({tag, "_hold_valid"}, o_valid, 1);
            chk({tag, "_hold_ready"}, o_ready, 0);
            check_result({tag, "_hold"}, e);
         end
         @(negedge i_clk);
         i_valid = 1'b0;
         i_ready = 1'b1;
      end
      @(posedge i_clk); #1;
      chk({tag, "_after_valid"}, o_valid, 0);
      chk({tag, "_after_ready"}, o_ready, 1);
   endtask

   initial begin
      int seen;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check_idle_outputs("reset");
      i_rst = 1'b0;

      run("hidden_sq",  24'h800000, 24'h800000, 0);
      run("max_sq",     24'hFFFFFF, 24'hFFFFFF, 0);
      run("zero_a",     24'h000000, 24'hC00000, 0);
      run("zero_b",     24'hA5A5A5, 24'h000000, 0);
      run("sat_pos",    24'h000001, 24'h400000, 0);
      run("mid_pos",    24'h00F000, 24'h00F000, 0);
      for (int i = 0; i < 4; i++)
         run("rand", 24'($urandom_range(1, 24'hFFFFFF)), 24'($urandom_range(1, 24'hFFFFFF)), 0);
      run("backpress",  24'hC00001, 24'h9ABCDE, 1);

      // Abort an operation twelve cycles into BUSY.
      @(negedge i_clk);
      i_valid  = 1'b1;
      i_mant_a = 24'h876543;
      i_mant_b = 24'hFEDCBA;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (12) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      check_idle_outputs("rst_busy");
      @(negedge i_clk);
      i_rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge i_clk); #1;
         if (o_valid) seen++;
      end
      chk("rst_no_valid", seen, 0);
      run("post_rst", 24'hFFFFFF, 24'h800000, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
